// File: rtl/imem_loader_pkg.sv
// Shared widths and FSM state encodings for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned ADDR_LEN  = 32;
  localparam int unsigned INSTR_LEN = 32;
  localparam int unsigned WC_W      = 17;

  typedef enum logic [2:0] {
    LDR_CLEAR = 3'd0,
    LDR_LOAD  = 3'd1,
    LDR_HOLD  = 3'd2,
    LDR_RUN   = 3'd3,
    LDR_ERROR = 3'd4
  } ldr_state_e;

endpackage

// File: rtl/imem_loader.sv
// Zero-fills instruction memory, streams a program into it, then releases the
// CPU from reset after a short hold; overflowing DEPTH latches an error state.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_LEN-1:0] in_data,
  input  logic                 in_last,
  output logic                 imem_we,
  output logic [ADDR_LEN-1:0]  imem_waddr,
  output logic [INSTR_LEN-1:0] imem_wdata,
  output logic                 cpu_rst,
  output logic                 load_done,
  output logic                 load_err,
  output logic [WC_W-1:0]      word_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned HC_W  = $clog2(HOLD_CYCLES + 1) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [HC_W-1:0]  HOLD_END = HC_W'(HOLD_CYCLES);

  ldr_state_e           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WC_W-1:0]      wc_q, wc_d;
  logic [HC_W-1:0]      hold_q, hold_d;
  logic                 we_q, we_d;
  logic [ADDR_LEN-1:0]  waddr_q, waddr_d;
  logic [INSTR_LEN-1:0] wdata_q, wdata_d;
  logic                 in_ready_q, in_ready_d;
  logic                 cpu_rst_q, cpu_rst_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 xfer_c;

  // in_ready_q is only ever set while the FSM sits in LOAD
  assign xfer_c = in_valid && in_ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LDR_CLEAR;
      idx_q      <= '0;
      wc_q       <= '0;
      hold_q     <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      in_ready_q <= 1'b0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wc_q       <= wc_d;
      hold_q     <= hold_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      in_ready_q <= in_ready_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wc_d    = wc_q;
    hold_d  = hold_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      LDR_CLEAR: begin
        we_d    = 1'b1;
        waddr_d = ADDR_LEN'(idx_q) << 2;
        wdata_d = 32'h0000_0000;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = LDR_LOAD;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      LDR_LOAD: begin
        if (xfer_c) begin
          we_d    = 1'b1;
          waddr_d = ADDR_LEN'(idx_q) << 2;
          wdata_d = in_data;
          idx_d   = idx_q + IDX_W'(1);
          wc_d    = wc_q + WC_W'(1);
          hold_d  = '0;
          // a last word in the final slot still fits, so in_last wins
          if (in_last) begin
            state_d = LDR_HOLD;
          end else if (idx_q == LAST_IDX) begin
            state_d = LDR_ERROR;
          end
        end
      end
      LDR_HOLD: begin
        // hold_q is 0 during the final strobe cycle, so HOLD_CYCLES more follow
        if (hold_q == HOLD_END) begin
          state_d = LDR_RUN;
        end else begin
          hold_d = hold_q + HC_W'(1);
        end
      end
      default: begin
      end
    endcase

    in_ready_d = (state_d == LDR_LOAD);
    cpu_rst_d  = (state_d != LDR_RUN);
    done_d     = (state_d == LDR_RUN);
    err_d      = (state_d == LDR_ERROR);
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign load_done  = done_q;
  assign load_err   = err_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a timing-level reference model predicts
// every write strobe, handshake and status output cycle by cycle.
module tb_imem_loader;

  localparam int DEPTH = 256;
  localparam int HOLD  = 2;
  localparam int NPROG = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_rst, load_done, load_err;
  logic [16:0] word_count;

  logic        rst4 = 1'b1;
  logic        v4 = 1'b0;
  logic        rdy4;
  logic [31:0] d4 = '0;
  logic        l4 = 1'b0;
  logic        we4;
  logic [31:0] waddr4, wdata4;
  logic        cpu_rst4, done4, err4;
  logic [16:0] wc4;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .cpu_rst(cpu_rst),
    .load_done(load_done), .load_err(load_err), .word_count(word_count)
  );

  imem_loader #(.DEPTH(4), .HOLD_CYCLES(HOLD)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(v4), .in_ready(rdy4),
    .in_data(d4), .in_last(l4), .imem_we(we4),
    .imem_waddr(waddr4), .imem_wdata(wdata4), .cpu_rst(cpu_rst4),
    .load_done(done4), .load_err(err4), .word_count(wc4)
  );

  int checks = 0;
  int failures = 0;

  // reference model: cycles since the last reset edge and the load progress
  int          cyc = 0;
  int          m_idx = 0;
  int          m_wc = 0;
  bit          m_closed = 0;
  bit          m_ok = 0;
  int          m_end_cyc = 0;
  bit          m_ready = 0;
  bit          m_xfer_prev = 0;
  logic [31:0] m_waddr, m_wdata;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] dut_mem   [DEPTH];
  logic [31:0] words     [NPROG];
  logic [63:0] q4 [$];

  localparam logic [31:0] PROG [NPROG] = '{
    32'h2009_000A, 32'h200A_0005, 32'h012A_5820, 32'h012A_6022,
    32'h012A_6824, 32'h012A_7025, 32'h012A_782A, 32'hAC0B_0000,
    32'h8C10_0000, 32'h1210_0002, 32'h2011_0001, 32'h2011_0002,
    32'h0230_9020, 32'hAC12_0004, 32'h8C13_0004, 32'h0253_A022,
    32'h1280_0001, 32'h2015_00FF, 32'h3C16_1234, 32'h36D6_5678,
    32'h0016_B880, 32'h02D7_C020, 32'hAC18_0008, 32'h0800_0000
  };

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: advance the model, then compare every DUT output against it
  task automatic tick();
    logic        rst_e, xfer, l, exp_we, exp_run, exp_err;
    logic [31:0] d, exp_addr, exp_data;
    rst_e = rst;
    xfer  = !rst && in_valid && m_ready;
    d     = in_data;
    l     = in_last;
    @(posedge clk);
    #1;
    if (rst_e) begin
      cyc = 0; m_idx = 0; m_wc = 0; m_closed = 0; m_ok = 0;
      m_end_cyc = 0; m_xfer_prev = 0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    end else begin
      cyc++;
      m_xfer_prev = xfer;
      if (xfer) begin
        m_waddr = 32'(m_idx * 4);
        m_wdata = d;
        model_mem[m_idx] = d;
        m_idx++;
        m_wc++;
        if (l || m_idx == DEPTH) begin
          m_closed = 1; m_ok = l; m_end_cyc = cyc;
        end
      end
    end
    m_ready  = (cyc >= DEPTH) && !m_closed;
    exp_we   = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    if (!rst_e && cyc >= 1 && cyc <= DEPTH) begin
      exp_we = 1'b1; exp_addr = 32'((cyc - 1) * 4); exp_data = 32'h0;
    end else if (!rst_e && m_xfer_prev) begin
      exp_we = 1'b1; exp_addr = m_waddr; exp_data = m_wdata;
    end
    exp_run = m_closed && m_ok && (cyc >= m_end_cyc + HOLD + 1);
    exp_err = m_closed && !m_ok;
    chk("imem_we", 64'(imem_we), 64'(exp_we));
    if (exp_we) begin
      chk("imem_waddr", 64'(imem_waddr), 64'(exp_addr));
      chk("imem_wdata", 64'(imem_wdata), 64'(exp_data));
    end
    chk("in_ready", 64'(in_ready), 64'(m_ready));
    chk("cpu_rst", 64'(cpu_rst), 64'(!exp_run));
    chk("load_done", 64'(load_done), 64'(exp_run));
    chk("load_err", 64'(load_err), 64'(exp_err));
    chk("word_count", 64'(word_count), 64'(m_wc));
    if (imem_we === 1'b1 && (imem_waddr >> 2) < DEPTH)
      dut_mem[int'(imem_waddr >> 2)] = imem_wdata;
    if (we4 === 1'b1) q4.push_back({waddr4, wdata4});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'($urandom);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // drive n words with the given valid duty; return early once stop_at words are in
  task automatic stream(input int n, input int duty, input int stop_at, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (m_wc >= stop_at) return;
      if (m_closed && cyc >= m_end_cyc + HOLD + 4) begin
        in_valid = 1'b0;
        return;
      end
      in_valid = (m_wc < n) && ($urandom_range(0, 99) < duty);
      in_data  = in_valid ? words[m_wc] : $urandom;
      in_last  = in_valid ? (m_wc == n - 1) : 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    chk("budget_load_finished", 64'(load_done | load_err), 64'd1);
  endtask

  task automatic check_image(input string tag);
    int nbad = 0;
    for (int i = 0; i < DEPTH; i++)
      if (dut_mem[i] !== model_mem[i]) nbad++;
    chk(tag, 64'(nbad), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) dut_mem[i] = 32'hDEAD_BEEF;
    for (int i = 0; i < NPROG; i++) words[i] = PROG[i];

    // reset, then abort partway through the zero-fill
    do_reset();
    for (int k = 0; k < 50; k++) begin
      in_valid = 1'b1; in_data = $urandom; in_last = 1'($urandom);
      tick();
    end
    do_reset();

    // full program, valid held high (also drives valid throughout CLEAR)
    stream(NPROG, 100, NPROG + 1, 2000);
    chk("a_word_count", 64'(word_count), 64'd24);
    chk("a_load_done", 64'(load_done), 64'd1);
    chk("a_imem23", 64'(dut_mem[23]), 64'h0800_0000);
    check_image("a_image");

    // random words with ~50% valid duty
    for (int i = 0; i < NPROG; i++) words[i] = $urandom;
    do_reset();
    stream(NPROG, 50, NPROG + 1, 2000);
    chk("b_word_count", 64'(word_count), 64'd24);
    check_image("b_image");

    // single-word program
    words[0] = 32'h2009_000A;
    do_reset();
    stream(1, 100, 2, 2000);
    chk("c_load_done", 64'(load_done), 64'd1);
    chk("c_imem0", 64'(dut_mem[0]), 64'h2009_000A);
    check_image("c_image");

    // reset after 10 words, then reload the full program
    for (int i = 0; i < NPROG; i++) words[i] = PROG[i];
    do_reset();
    stream(NPROG, 100, 10, 2000);
    chk("d_partial_count", 64'(word_count), 64'd10);
    do_reset();
    stream(NPROG, 50, NPROG + 1, 2000);
    check_image("d_image");

    // overflow on a DEPTH=4 instance
    rst4 = 1'b1;
    tick();
    tick();
    q4.delete();
    rst4 = 1'b0;
    v4 = 1'b1;
    l4 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      d4 = 32'hC0DE_0000 + 32'(k);
      tick();
    end
    chk("e_write_count", 64'(q4.size()), 64'd8);
    for (int i = 0; i < 8 && i < q4.size(); i++) begin
      if (i < 4) chk("e_zero_write", q4[i], {32'(i * 4), 32'h0});
      else chk("e_data_write", q4[i], {32'((i - 4) * 4), 32'hC0DE_0004 + 32'(i - 4)});
    end
    chk("e_word_count", 64'(wc4), 64'd4);
    chk("e_load_done", 64'(done4), 64'd0);
    for (int k = 0; k < 5; k++) begin
      d4 = $urandom;
      l4 = 1'($urandom);
      tick();
      chk("e_load_err", 64'(err4), 64'd1);
      chk("e_cpu_rst", 64'(cpu_rst4), 64'd1);
      chk("e_in_ready", 64'(rdy4), 64'd0);
    end
    chk("e_no_more_writes", 64'(q4.size()), 64'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning instruction-memory size in words (power of two, 4..65536).
REQ-002 SHALL have parameter HOLD_CYCLES, default 2, meaning cycles cpu_rst stays high after the last word is written.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit, meaning the source presents a word.
REQ-006 SHALL have port in_ready, output, 1 bit, meaning the loader accepts a word this cycle.
REQ-007 SHALL have port in_data, input, `INSTR_LEN bits, meaning the instruction word.
REQ-008 SHALL have port in_last, input, 1 bit, meaning in_data is the final program word.
REQ-009 SHALL have port imem_we, output, 1 bit, meaning the instruction-memory write strobe.
REQ-010 SHALL have port imem_waddr, output, `ADDR_LEN bits, meaning the byte address, word-aligned (index*4).
REQ-011 SHALL have port imem_wdata, output, `INSTR_LEN bits, meaning the write data.
REQ-012 SHALL have port cpu_rst, output, 1 bit, meaning the reset driven to cpu.rst.
REQ-013 SHALL have port load_done, output, 1 bit, meaning the program is loaded and the CPU is running.
REQ-014 SHALL have port load_err, output, 1 bit, meaning the program overflowed DEPTH.
REQ-015 SHALL have port word_count, output, 17 bits, meaning the number of words accepted since reset.

Function
REQ-016 SHALL implement FSM states CLEAR, LOAD, HOLD, RUN, ERROR, with the state held in a register.
REQ-017 In CLEAR, SHALL write 32'h0000_0000 to indices 0..DEPTH-1, one per cycle, then enter LOAD; in_ready=0 during CLEAR.
REQ-018 In LOAD, in_ready SHALL be 1; a transfer SHALL occur exactly when in_valid && in_ready.
REQ-019 On a transfer, SHALL assert imem_we one cycle later with imem_waddr=idx*4 and imem_wdata=in_data (1-cycle latency), then increment idx and word_count.
REQ-020 A transfer with in_last=1 SHALL move the FSM to HOLD; in_ready SHALL be 0 from the next cycle.
REQ-021 A transfer at idx=DEPTH-1 with in_last=0 SHALL still write that word, then move to ERROR.
REQ-022 HOLD SHALL last exactly HOLD_CYCLES cycles, counted from the cycle after the final write strobe, then enter RUN.
REQ-023 cpu_rst SHALL be 1 in CLEAR, LOAD, HOLD and ERROR, and 0 only in RUN.
REQ-024 load_done SHALL be 1 only in RUN; load_err SHALL be 1 only in ERROR.
REQ-025 RUN and ERROR SHALL be terminal until rst; in_ready=0 and imem_we=0 in both.
REQ-026 imem_we SHALL never be asserted outside CLEAR and the single cycle following a LOAD transfer.
REQ-027 in_data and in_last SHALL be ignored whenever no transfer occurs.

Reset
REQ-028 While rst=1 at a clock edge, SHALL set state=CLEAR, idx=0, word_count=0, imem_we=0, in_ready=0, cpu_rst=1, load_done=0, load_err=0.
REQ-029 rst asserted mid-CLEAR, mid-LOAD, in HOLD or in RUN SHALL restart from CLEAR at index 0; partially loaded words are discarded by the zero-fill.

Structure
REQ-030 `ADDR_LEN and `INSTR_LEN SHALL come from defines.v; FSM state encodings SHALL be added there as `LDR_* constants.
REQ-031 SHALL be a single module with no sub-modules; the top level instantiates it beside cpu and drives cpu.rst from cpu_rst and the imem write port from imem_*.

Verification
REQ-032 Stream the 24-word ALU/lw/sw/beq/j test program (DEPTH=256, in_valid held high) -> 256 zero writes, 24 writes at 0x00..0x5C, imem[23]=32'h0800_0000, cpu_rst falls 2 cycles after the last strobe, word_count=24.
REQ-033 Toggle in_valid with a pseudo-random 50% duty -> exactly one write per accepted word, in order, no duplicates or gaps.
REQ-034 DEPTH=4, send 4 words with in_last=0 -> 4 writes, then load_err=1, cpu_rst=1, in_ready=0 permanently.
REQ-035 Single word 32'h2009_000A with in_last=1 -> one write at 0x0, load_done=1 after HOLD_CYCLES, remaining words 0.
REQ-036 Drive in_valid=1 during CLEAR -> no transfer, no data write, word_count stays 0.
REQ-037 Assert rst after 10 of 24 words, then reload -> full zero-fill repeats, final imem matches the program, and imem[10..] never holds stale data.
